pcm_pio_in_irq: RTL and testbench

PCM_PIO_IN_IRQ -- requirements
Module: pcm_pio_in_irq

---
 rtl/pcm_pio_pkg.sv | 7 +
 rtl/pcm_pio_debounce.sv | 33 +++
 rtl/pcm_pio_in_irq.sv | 55 +++++
 tb/tb_pcm_pio_in_irq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pcm_pio_pkg.sv
// pcm_pio_pkg: register map and edge-detect mode shared by the PIO input block
package pcm_pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  typedef enum logic [1:0] {RISING, FALLING, ANY} edge_mode_t;
endpackage

// File: rtl/pcm_pio_debounce.sv
// pcm_pio_debounce: per-bit 2-flop synchroniser followed by an optional stability filter
module pcm_pio_debounce #(
  parameter int unsigned N = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic f_o
);
  logic s1_q, s2_q, f_q, f_d;
  always_ff @(posedge clk)
    if (reset) {s1_q, s2_q, f_q} <= '0;
    else {s1_q, s2_q, f_q} <= {d_i, s1_q, f_d};
  generate
    if (N == 0) begin : g_byp
      assign f_d = s2_q;
    end else begin : g_deb
      localparam int unsigned CW = $clog2(N + 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic diff, hit;
      always_comb begin
        diff  = s2_q != f_q;
        hit   = diff && cnt_q == CW'(N - 1);
        cnt_d = diff && !hit ? cnt_q + 1'b1 : '0;
      end
      assign f_d = hit ? s2_q : f_q;
      always_ff @(posedge clk)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
  endgenerate
  assign f_o = f_q;
endmodule

// File: rtl/pcm_pio_in_irq.sv
// pcm_pio_in_irq: Avalon-MM PIO input with debounce, edge capture and masked level interrupt
module pcm_pio_in_irq
  import pcm_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter edge_mode_t  EDGE_MODE       = RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] f, f_dly_q, mask_q, mask_d, cap_q, cap_d, clr, edge_w;
  logic [31:0] rd_q, rd_d;
  logic irq_q, irq_d, unused_w;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcm_pio_debounce #(.N(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .reset(reset),
      .d_i(in_port[i]),
      .f_o(f[i])
    );
  end
  always_comb begin
    edge_w = EDGE_MODE == RISING ? f & ~f_dly_q : EDGE_MODE == FALLING ? ~f & f_dly_q : f ^ f_dly_q;
    clr    = write && address == ADDR_EDGE ? writedata[WIDTH-1:0] : '0;
    cap_d  = (cap_q & ~clr) | edge_w;
    mask_d = write && address == ADDR_MASK ? writedata[WIDTH-1:0] : mask_q;
    irq_d  = |(cap_q & mask_q);
    rd_d   = address == ADDR_DATA ? 32'(f) : address == ADDR_MASK ? 32'(mask_q) :
             address == ADDR_EDGE ? 32'(cap_q) : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      f_dly_q <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rd_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      f_dly_q <= f;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      irq_q   <= irq_d;
    end
  assign unused_w = ^writedata;
  assign readdata = rd_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_pcm_pio_in_irq.sv
// tb_pcm_pio_in_irq: directed stimulus with queued expectations checked by an independent monitor
module tb_pcm_pio_in_irq;
  import pcm_pio_pkg::*;
  logic clk = 1'b0, reset = 1'b1, mon_req = 1'b0, rv_q = 1'b0;
  logic [1:0] address = '0;
  logic [31:0] writedata = '0;
  logic [3:0] wr = '0;
  logic [7:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [31:0] rd_w [4];
  logic irq_w [4];
  int n_cmp = 0, n_bad = 0;
  typedef struct { int sel; string name; logic [31:0] rd; logic irq; } exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  pcm_pio_in_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE(RISING)) u_a (
    .clk(clk), .reset(reset), .address(address), .write(wr[0]), .writedata(writedata),
    .in_port(in_a), .readdata(rd_w[0]), .irq(irq_w[0]));
  pcm_pio_in_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(RISING)) u_b (
    .clk(clk), .reset(reset), .address(address), .write(wr[1]), .writedata(writedata),
    .in_port(in_b), .readdata(rd_w[1]), .irq(irq_w[1]));
  pcm_pio_in_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE(ANY)) u_c (
    .clk(clk), .reset(reset), .address(address), .write(wr[2]), .writedata(writedata),
    .in_port(in_c), .readdata(rd_w[2]), .irq(irq_w[2]));
  pcm_pio_in_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE(FALLING)) u_d (
    .clk(clk), .reset(reset), .address(address), .write(wr[3]), .writedata(writedata),
    .in_port(in_d), .readdata(rd_w[3]), .irq(irq_w[3]));
  always @(posedge clk) rv_q <= mon_req;
  always @(negedge clk)
    if (rv_q) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: DUT presented readdata with no expectation queued");
      end else begin
        e = q.pop_front();
        if (rd_w[e.sel] !== e.rd || irq_w[e.sel] !== e.irq) begin
          n_bad++;
          $display("FAIL %s: got readdata=%h irq=%b, expected readdata=%h irq=%b",
                   e.name, rd_w[e.sel], irq_w[e.sel], e.rd, e.irq);
        end
      end
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(input int s, input logic [1:0] a, input logic [31:0] er, input logic ei, input string nm);
    address = a;
    q.push_back('{s, nm, er, ei});
    mon_req = 1'b1;
    tick(1);
    mon_req = 1'b0;
  endtask
  task automatic wrt(input int s, input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    wr[s] = 1'b1;
    tick(1);
    wr = '0;
  endtask
  initial begin
    tick(2);
    reset = 1'b0;
    rd(0, 0, 32'h0, 1'b0, "reset_data");
    rd(0, 1, 32'h0, 1'b0, "reset_reserved");
    rd(0, 2, 32'h0, 1'b0, "reset_mask");
    rd(0, 3, 32'h0, 1'b0, "reset_edge");
    wrt(0, 2, 32'h1);
    in_a = 8'h05;
    tick(3);
    rd(0, 3, 32'h0, 1'b0, "edge_not_yet");
    rd(0, 3, 32'h05, 1'b1, "edge_after_3_irq");
    rd(0, 0, 32'h05, 1'b1, "data_filtered");
    rd(0, 2, 32'h01, 1'b1, "mask_readback");
    wrt(0, 0, 32'hFF);
    wrt(0, 1, 32'hFF);
    rd(0, 0, 32'h05, 1'b1, "data_write_ignored");
    rd(0, 1, 32'h0, 1'b1, "reserved_reads_zero");
    wrt(0, 2, 32'hFFFF_FF01);
    rd(0, 2, 32'h01, 1'b1, "mask_upper_ignored");
    wrt(0, 3, 32'h04);
    rd(0, 3, 32'h01, 1'b1, "w1c_partial_irq_held");
    wrt(0, 3, 32'h01);
    rd(0, 3, 32'h0, 1'b0, "w1c_full_irq_drops");
    in_a = 8'h01;
    tick(5);
    in_a = 8'h05;
    tick(3);
    wrt(0, 3, 32'h04);
    rd(0, 3, 32'h04, 1'b0, "set_wins_over_clear");
    wrt(0, 3, 32'h04);
    rd(0, 3, 32'h0, 1'b0, "clear_after_set");
    in_b = 8'h01;
    tick(3);
    in_b = 8'h00;
    tick(8);
    rd(1, 0, 32'h0, 1'b0, "glitch_data");
    rd(1, 3, 32'h0, 1'b0, "glitch_no_edge");
    in_b = 8'h01;
    tick(5);
    rd(1, 0, 32'h0, 1'b0, "debounce_not_yet");
    rd(1, 0, 32'h01, 1'b0, "debounce_stable");
    wrt(1, 2, 32'hFF);
    rd(1, 3, 32'h01, 1'b1, "debounce_edge_irq");
    in_c = 8'h08;
    tick(6);
    wrt(2, 3, 32'h08);
    rd(2, 3, 32'h0, 1'b0, "any_cleared");
    in_c = 8'h00;
    tick(6);
    rd(2, 3, 32'h08, 1'b0, "any_falling_captured");
    in_d = 8'h08;
    tick(6);
    rd(3, 3, 32'h0, 1'b0, "falling_ignores_rise");
    in_d = 8'h00;
    tick(6);
    rd(3, 3, 32'h08, 1'b0, "falling_captured");
    in_b = 8'h00;
    tick(3);
    reset = 1'b1;
    rd(1, 3, 32'h0, 1'b0, "reset_mid_debounce");
    reset = 1'b0;
    rd(1, 2, 32'h0, 1'b0, "reset_cleared_mask");
    tick(4);
    rd(0, 3, 32'h05, 1'b0, "high_through_reset");
    tick(2);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
